// File: rtl/line_clear_ctrl.sv
// line_clear_ctrl: line-clear sequencer that captures the board, repeatedly clears full rows, optionally flashes them, then writes back and scores
// Optional feature macro: LINE_CLEAR_FLASH_EN (adds the FLASH state and drives flash_mask_o / flash_phase_o).
// Ports:
//   clk, rst                      clock and asynchronous active-high reset
//   start_i, board_in_i           lock-event pulse (accepted only when idle) and the board captured with it
//   busy_o                        high in every state except IDLE
//   board_out_o, board_we_o       collapsed board and its one-cycle write strobe
//   done_o                        one-cycle completion pulse, coincident with board_we_o
//   lines_cleared_o               rows removed by the last sequence (0..20)
//   lines_total_o, score_o        saturating running line count and score
//   flash_mask_o, flash_phase_o   full rows of the first scan and renderer blink phase
module line_clear_ctrl #(
  parameter int FLASH_PERIOD = 12_500_000,
  parameter int FLASH_TOGGLES = 4,
  localparam int ROWS = 20,
  localparam int COLS = 12,
  localparam int BOARD_SIZE = ROWS * COLS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [BOARD_SIZE-1:0] board_in_i,
  output logic                  busy_o,
  output logic [BOARD_SIZE-1:0] board_out_o,
  output logic                  board_we_o,
  output logic                  done_o,
  output logic [4:0]            lines_cleared_o,
  output logic [15:0]           lines_total_o,
  output logic [19:0]           score_o,
  output logic [19:0]           flash_mask_o,
  output logic                  flash_phase_o
);
  if (FLASH_PERIOD < 1 || FLASH_TOGGLES < 1) begin : g_bad_cfg
    $error("line_clear_ctrl: FLASH_PERIOD and FLASH_TOGGLES must both be at least 1");
  end
  typedef enum logic [2:0] {IDLE, SCAN, FLASH, COLLAPSE, DONE} state_t;
  state_t                state_q;
  logic [BOARD_SIZE-1:0] work_q, board_out_q;
  logic                  busy_q, board_we_q, done_q;
  logic [4:0]            lines_cleared_q;
  logic [15:0]           lines_total_q, lines_total_d;
  logic [19:0]           score_q, score_d;
  logic [ROWS-1:0]       full;
  logic [4:0]            lo;
  logic [3:0]            run;
  logic [2:0]            num;
  logic [7:0]            sh_lo, sh_hi;
  logic [BOARD_SIZE-1:0] new_board;
  logic [9:0]            award;
  logic [16:0]           lt_sum;
  logic [20:0]           sc_sum;
  // lo ends up at the lowest full row (0 when none, where num then evaluates to 0)
  always_comb begin
    full = '0;
    lo = '0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      full[r] = &work_q[r*COLS +: COLS];
      lo = full[r] ? 5'(r) : lo;
    end
  end
  // length of the contiguous full run starting at lo, capped at 4 rows per pass
  assign run = 4'(full >> lo);
  assign num = !run[0] ? 3'd0 : !run[1] ? 3'd1 : !run[2] ? 3'd2 : !run[3] ? 3'd3 : 3'd4;
  assign sh_lo = 8'(lo) * 8'd12;
  assign sh_hi = 8'(lo + 5'(num)) * 8'd12;
  // keep rows below the run, drop the run and pull everything above it down; zeros fill in at the top
  assign new_board = (work_q & ~({BOARD_SIZE{1'b1}} << sh_lo)) | ((work_q >> sh_hi) << sh_lo);
  assign award = lines_cleared_q == 5'd0 ? 10'd0 : lines_cleared_q == 5'd1 ? 10'd100 :
                 lines_cleared_q == 5'd2 ? 10'd300 : lines_cleared_q == 5'd3 ? 10'd500 : 10'd800;
  assign lt_sum = {1'b0, lines_total_q} + 17'(lines_cleared_q);
  assign sc_sum = {1'b0, score_q} + 21'(award);
  assign lines_total_d = lt_sum[16] ? 16'hFFFF : lt_sum[15:0];
  assign score_d = sc_sum[20] ? 20'hFFFFF : sc_sum[19:0];
`ifdef LINE_CLEAR_FLASH_EN
  logic        first_q, flash_phase_q;
  logic [19:0] flash_mask_q;
  logic [31:0] flash_cnt_q, flash_tog_q;
  assign flash_mask_o = flash_mask_q;
  assign flash_phase_o = flash_phase_q;
`else
  assign flash_mask_o = '0;
  assign flash_phase_o = 1'b0;
`endif
  assign busy_o = busy_q;
  assign board_out_o = board_out_q;
  assign board_we_o = board_we_q;
  assign done_o = done_q;
  assign lines_cleared_o = lines_cleared_q;
  assign lines_total_o = lines_total_q;
  assign score_o = score_q;
  // outputs are loaded on the edge entering their state so DONE's strobe and data appear together in the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      work_q <= '0;
      busy_q <= 1'b0;
      board_out_q <= '0;
      board_we_q <= 1'b0;
      done_q <= 1'b0;
      lines_cleared_q <= '0;
      lines_total_q <= '0;
      score_q <= '0;
`ifdef LINE_CLEAR_FLASH_EN
      first_q <= 1'b0;
      flash_mask_q <= '0;
      flash_phase_q <= 1'b0;
      flash_cnt_q <= '0;
      flash_tog_q <= '0;
`endif
    end else begin
      board_we_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (start_i) begin
          state_q <= SCAN;
          busy_q <= 1'b1;
          work_q <= board_in_i;
          lines_cleared_q <= '0;
`ifdef LINE_CLEAR_FLASH_EN
          first_q <= 1'b1;
`endif
        end
        SCAN: if (num == 3'd0) begin
          state_q <= DONE;
          board_out_q <= work_q;
          board_we_q <= 1'b1;
          done_q <= 1'b1;
          lines_total_q <= lines_total_d;
          score_q <= score_d;
        end else begin
`ifdef LINE_CLEAR_FLASH_EN
          if (first_q) begin
            flash_mask_q <= full;
            flash_phase_q <= 1'b1;
            flash_cnt_q <= '0;
            flash_tog_q <= '0;
          end
          state_q <= first_q ? FLASH : COLLAPSE;
`else
          state_q <= COLLAPSE;
`endif
        end
`ifdef LINE_CLEAR_FLASH_EN
        FLASH: if (flash_cnt_q == 32'(FLASH_PERIOD - 1)) begin
          flash_cnt_q <= '0;
          if (flash_tog_q == 32'(FLASH_TOGGLES - 1)) state_q <= COLLAPSE;
          else begin
            flash_tog_q <= flash_tog_q + 32'd1;
            flash_phase_q <= ~flash_phase_q;
          end
        end else flash_cnt_q <= flash_cnt_q + 32'd1;
`endif
        COLLAPSE: begin
          state_q <= SCAN;
          work_q <= new_board;
          lines_cleared_q <= lines_cleared_q + 5'(num);
`ifdef LINE_CLEAR_FLASH_EN
          first_q <= 1'b0;
`endif
        end
        DONE: begin
          state_q <= IDLE;
          busy_q <= 1'b0;
`ifdef LINE_CLEAR_FLASH_EN
          flash_mask_q <= '0;
          flash_phase_q <= 1'b0;
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb_line_clear_ctrl: scoreboard bench for line_clear_ctrl with directed boards and saturation runs
module tb_line_clear_ctrl;
  localparam int FP = 2;
  localparam int FT = 4;
`ifdef LINE_CLEAR_FLASH_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  localparam int FX = FE ? FP * FT : 0;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [239:0] board_in_i = '0;
  logic         busy_o, board_we_o, done_o, flash_phase_o;
  logic [239:0] board_out_o;
  logic [4:0]   lines_cleared_o;
  logic [15:0]  lines_total_o;
  logic [19:0]  score_o, flash_mask_o;
  typedef struct {
    int t;
    logic [239:0] b;
    int lc;
    int lt;
    int sc;
    logic [19:0] fm;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, errors = 0, checks = 0;
  int exp_lt = 0, exp_sc = 0, last_t = 0, last_done = -10, we_pulses = 0;
  logic ph [16];
  line_clear_ctrl #(.FLASH_PERIOD(FP), .FLASH_TOGGLES(FT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .board_in_i(board_in_i),
    .busy_o(busy_o), .board_out_o(board_out_o), .board_we_o(board_we_o), .done_o(done_o),
    .lines_cleared_o(lines_cleared_o), .lines_total_o(lines_total_o), .score_o(score_o),
    .flash_mask_o(flash_mask_o), .flash_phase_o(flash_phase_o)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int award(int lc);
    return lc == 0 ? 0 : lc == 1 ? 100 : lc == 2 ? 300 : lc == 3 ? 500 : 800;
  endfunction
  function automatic logic [239:0] frows(int lo, int cnt);
    logic [239:0] b = '0;
    for (int r = lo; r < lo + cnt; r++) b[r*12 +: 12] = 12'hFFF;
    return b;
  endfunction
  task automatic chk(input string name, input logic [239:0] act, input logic [239:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
    end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 240'(busy_o), 240'(0));
    chk({tag, "_board_out"}, board_out_o, 240'(0));
    chk({tag, "_board_we"}, 240'(board_we_o), 240'(0));
    chk({tag, "_done"}, 240'(done_o), 240'(0));
    chk({tag, "_lines_cleared"}, 240'(lines_cleared_o), 240'(0));
    chk({tag, "_lines_total"}, 240'(lines_total_o), 240'(0));
    chk({tag, "_score"}, 240'(score_o), 240'(0));
    chk({tag, "_flash_mask"}, 240'(flash_mask_o), 240'(0));
    chk({tag, "_flash_phase"}, 240'(flash_phase_o), 240'(0));
  endtask
  task automatic monitor();
    exp_t e;
    int d;
    forever begin
      @(negedge clk);
      d = cyc - last_t;
      if (d >= 0 && d < 16) ph[d] = flash_phase_o;
      if (cyc == last_done + 1) chk("busy_after_done", 240'(busy_o), 240'(0));
      if (done_o || board_we_o) begin
        we_pulses++;
        last_done = cyc;
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done at cycle %0d: done=%0b board_we=%0b with nothing outstanding", cyc, done_o, board_we_o);
        end else begin
          e = sb.pop_front();
          chk("latency", 240'(cyc), 240'(e.t));
          chk("done", 240'(done_o), 240'(1));
          chk("board_we", 240'(board_we_o), 240'(1));
          chk("busy_in_done", 240'(busy_o), 240'(1));
          chk("board_out", board_out_o, e.b);
          chk("lines_cleared", 240'(lines_cleared_o), 240'(e.lc));
          chk("lines_total", 240'(lines_total_o), 240'(e.lt));
          chk("score", 240'(score_o), 240'(e.sc));
          chk("flash_mask", 240'(flash_mask_o), 240'(e.fm));
        end
      end
    end
  endtask
  // n = clear passes needed, poke = also pulse start (with an all-full board) while busy
  task automatic run(input logic [239:0] b, input logic [239:0] ob, input int lc, input int n,
                     input logic [19:0] fm, input bit poke);
    exp_t e;
    @(negedge clk);
    start_i = 1'b1;
    board_in_i = b;
    last_t = cyc;
    exp_lt = (exp_lt + lc > 65535) ? 65535 : exp_lt + lc;
    exp_sc = (exp_sc + award(lc) > 1048575) ? 1048575 : exp_sc + award(lc);
    e.t = cyc + 2 + 2 * n + (n > 0 ? FX : 0);
    e.b = ob;
    e.lc = lc;
    e.lt = exp_lt;
    e.sc = exp_sc;
    e.fm = FE ? fm : 20'h0;
    sb.push_back(e);
    @(negedge clk);
    start_i = poke;
    board_in_i = poke ? '1 : '0;
    @(negedge clk);
    start_i = 1'b0;
    board_in_i = '0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout at cycle %0d: done never arrived, %0d outstanding", cyc, sb.size());
      sb.delete();
    end
  endtask
  initial begin
    logic [239:0] b, ob;
    logic [7:0] ph_exp;
    int wp;
    ph_exp = FE ? 8'b0011_0011 : 8'b0;
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("after_reset");
    run('0, '0, 0, 0, 20'h0, 1'b0);
    b = '0;
    b[84 +: 12] = 12'h7FF;
    run(b, b, 0, 0, 20'h0, 1'b0);
    run(frows(0, 1), '0, 1, 1, 20'h00001, 1'b0);
    b = frows(0, 1) | frows(2, 1);
    b[12 +: 12] = 12'h001;
    run(b, 240'h001, 2, 2, 20'h00005, 1'b0);
    b = frows(3, 4);
    b[84 +: 12] = 12'hABC;
    ob = '0;
    ob[36 +: 12] = 12'hABC;
    run(b, ob, 4, 1, 20'h00078, 1'b0);
    for (int i = 0; i < 8; i++) chk("flash_phase_seq", 240'(ph[i + 2]), 240'(ph_exp[i]));
    run(frows(0, 5), '0, 5, 2, 20'h0001F, 1'b0);
    b = frows(0, 1) | frows(2, 1);
    b[12 +: 12] = 12'h001;
    run(b, 240'h001, 2, 2, 20'h00005, 1'b1);
    chk("lines_cleared_hold", 240'(lines_cleared_o), 240'(2));
    @(negedge clk);
    start_i = 1'b1;
    board_in_i = b;
    last_t = cyc;
    @(negedge clk);
    start_i = 1'b0;
    board_in_i = '0;
    repeat (FX + 1) @(negedge clk);
    chk("busy_mid_sequence", 240'(busy_o), 240'(1));
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    @(negedge clk);
    chk_zero("held_reset");
    rst = 1'b0;
    wp = we_pulses;
    repeat (30) @(negedge clk);
    chk("no_we_after_reset", 240'(we_pulses), 240'(wp));
    exp_lt = 0;
    exp_sc = 0;
    for (int i = 0; i < 1310; i++) run('1, '0, 20, 5, 20'hFFFFF, 1'b0);
    run(frows(0, 3), '0, 3, 1, 20'h00007, 1'b0);
    run(frows(0, 4), '0, 4, 1, 20'h0000F, 1'b0);
    for (int i = 0; i < 1966; i++) run('1, '0, 20, 5, 20'hFFFFF, 1'b0);
    run(frows(0, 7), '0, 7, 2, 20'h0007F, 1'b0);
    run(frows(0, 4), '0, 4, 1, 20'h0000F, 1'b0);
    run(frows(0, 1), '0, 1, 1, 20'h00001, 1'b0);
    chk("score_saturated", 240'(score_o), 240'(1048575));
    chk("lines_total_saturated", 240'(lines_total_o), 240'(65535));
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
